div_controller: RTL and testbench
=================================

Name: div_controller

Overview:
- Sequencing controller for the 32-bit iterative signed divider core. That core is magnitude-only, has a level `start`, a `fim` completion flag and a `DividedByZero` flag.
- Accepts divide requests from the CPU execute stage and screens out divide-by-zero without running the core.
- Drives the core's start/operand handshake, applies sign correction to quotient and remainder, owns the architectural HI/LO registers, and stalls the CPU while busy.

Parameters:
- WIDTH, 32, operand/result width.
- ARM_CYCLES, 2, cycles after div_start rises during which div_fim is ignored; covers a stale or unreset fim in the core.
- TIMEOUT, 48, cycles in RUN before the watchdog aborts.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  CPU requests a signed divide this cycle.
- op_dividend  in  WIDTH  dividend (two's complement).
- op_divisor  in  WIDTH  divisor (two's complement).
- busy  out  1  controller not in IDLE; CPU must stall further mult/div/mfhi/mflo.
- done  out  1  one-cycle pulse: operation finished (result, div-by-zero or timeout).
- div_zero  out  1  one-cycle pulse with done: divisor was 0.
- timeout_err  out  1  one-cycle pulse with done: watchdog fired.
- hi  out  WIDTH  architectural HI (remainder).
- lo  out  WIDTH  architectural LO (quotient).
- div_start  out  1  level start to the core.
- div_dividendo  out  WIDTH  held operand to the core.
- div_divisor  out  WIDTH  held operand to the core.
- div_lo  in  WIDTH  core quotient magnitude.
- div_hi  in  WIDTH  core remainder magnitude.
- div_fim  in  1  core completion flag.

Behaviour:
- Reset (sync, high): state=IDLE. busy, done, div_zero, timeout_err, div_start = 0; hi = lo = 0; div_dividendo = div_divisor = 0; counters = 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - op_valid=1 and op_divisor==0: latch nothing, go to DONE with div_zero set. div_start never rises; hi/lo unchanged.
  - op_valid=1 and op_divisor!=0: register operands into div_dividendo/div_divisor. Record neg_q = dividend[31]^divisor[31] and neg_r = dividend[31]. Clear cycle counter; go to RUN.
  - op_valid ignored in every state other than IDLE.
- RUN:
  - div_start=1 on every cycle; operands held stable; counter increments each cycle.
  - div_fim is ignored while counter < ARM_CYCLES.
  - Otherwise div_fim=1 moves to FIX; div_start drops to 0 in the FIX cycle.
  - counter == TIMEOUT with no qualified fim: go to DONE with timeout_err set; div_start=0; hi/lo unchanged.
- FIX (one cycle), then go to DONE:
  - lo <= neg_q ? -div_lo : div_lo.
  - hi <= neg_r ? -div_hi : div_hi.
  - All arithmetic is WIDTH-bit wrap-around.
- DONE (one cycle): done=1, plus div_zero/timeout_err if flagged; then go to IDLE.
- busy = (state != IDLE). busy rises the cycle after acceptance and is low in the cycle after DONE.
- Latency:
  - Normal divide: accept edge → done = RUN length (core load + 32 iterations + fim, nominally 34 cycles) + FIX + DONE.
  - Bench requirement: done within ARM_CYCLES+TIMEOUT+2 of accept, and exactly 2 cycles after the first qualified div_fim sample.
  - Divide-by-zero: done 1 cycle after accept.
- Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. No overflow flag.
- hi/lo change only in FIX (and at reset); they are stable in all other cycles.
- op_valid and done in the same cycle: no interaction, since the request is taken only in IDLE, which follows DONE.
- Reset mid-RUN: immediate return to IDLE, div_start=0 on the next cycle, hi/lo cleared. The core shares reset.

Decomposition:
- Shared package div_ctrl_pkg:
  - state enum {IDLE, RUN, FIX, DONE};
  - WIDTH default;
  - ARM_CYCLES;
  - TIMEOUT.
- Sub-module div_sign_fix: purely combinational.
  - Inputs: magnitudes, neg_q, neg_r.
  - Outputs: signed quotient/remainder.
  - Instantiated once, feeding FIX.

Test Plan:
- 100 / 7 → done, lo=14, hi=2, div_zero=0; busy high throughout; div_start high only in RUN.
- -100 / 7 (0xFFFFFF9C / 7) → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- 100 / -7 → lo=0xFFFFFFF2, hi=2.
- 5 / 0 → done and div_zero 1 cycle after accept; div_start never high; prior hi/lo retained.
- 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stub core never asserting fim → timeout_err+done at TIMEOUT, div_start returns to 0.
- Assert reset 10 cycles into RUN → IDLE, hi=lo=0.
- Back-to-back 50/3 then 9/4 → lo=16,hi=2 then lo=2,hi=1; no stale fim accepted.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and default sizing for the divider sequencing controller.
package div_ctrl_pkg;
  localparam int DIV_WIDTH      = 32;
  localparam int DIV_ARM_CYCLES = 2;
  localparam int DIV_TIMEOUT    = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_sign_fix.sv
// Applies two's-complement sign to the core's quotient/remainder magnitudes.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_mag_q,
  input  logic [WIDTH-1:0] i_mag_r,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r
);
  // Plain wrap-around negate: INT_MIN / -1 yields INT_MIN with no flag.
  assign o_q = i_neg_q ? (~i_mag_q + WIDTH'(1)) : i_mag_q;
  assign o_r = i_neg_r ? (~i_mag_r + WIDTH'(1)) : i_mag_r;
endmodule

// File: rtl/div_controller.sv
// Sequencer around the iterative divider core: screens /0, arms and watches fim,
// sign-fixes the result into HI/LO and stalls the CPU while busy.
module div_controller
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int ARM_CYCLES = DIV_ARM_CYCLES,
  parameter int TIMEOUT    = DIV_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_dividend,
  input  logic [WIDTH-1:0] op_divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividendo,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic             div_fim
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r;
  logic             r_busy, r_done, r_dz, r_to, r_start;
  logic [WIDTH-1:0] r_hi, r_lo, r_dvd, r_dvs;
  logic [WIDTH-1:0] w_q, w_r;
  logic             w_fim_ok;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_mag_q (div_lo),
    .i_mag_r (div_hi),
    .i_neg_q (r_neg_q),
    .i_neg_r (r_neg_r),
    .o_q     (w_q),
    .o_r     (w_r)
  );

  // fim from the core may be stale from the previous op until it sees start.
  assign w_fim_ok = div_fim && (r_cnt >= CW'(ARM_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_to    <= 1'b0;
      r_start <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (op_valid) begin
            r_busy <= 1'b1;
            if (op_divisor == '0) begin
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dvd   <= op_dividend;
              r_dvs   <= op_divisor;
              r_neg_q <= op_dividend[WIDTH-1] ^ op_divisor[WIDTH-1];
              r_neg_r <= op_dividend[WIDTH-1];
              r_cnt   <= '0;
              r_start <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_fim_ok) begin
            r_start <= 1'b0;
            r_state <= FIX;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_start <= 1'b0;
            r_to    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FIX: begin
          r_lo    <= w_q;
          r_hi    <= w_r;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_to    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign div_zero      = r_dz;
  assign timeout_err   = r_to;
  assign hi            = r_hi;
  assign lo            = r_lo;
  assign div_start     = r_start;
  assign div_dividendo = r_dvd;
  assign div_divisor   = r_dvs;
endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller with a behavioural magnitude-divider core.
module tb_div_controller;
  import div_ctrl_pkg::*;
  localparam int W   = DIV_WIDTH;
  localparam int ARM = DIV_ARM_CYCLES;
  localparam int TMO = DIV_TIMEOUT;

  logic         clock = 1'b0, reset = 1'b1, op_valid = 1'b0;
  logic [W-1:0] op_dividend = '0, op_divisor = '0;
  logic         busy, done, div_zero, timeout_err, div_start, div_fim;
  logic [W-1:0] hi, lo, div_dividendo, div_divisor, div_lo, div_hi;

  div_controller dut (
    .clock(clock), .reset(reset), .op_valid(op_valid),
    .op_dividend(op_dividend), .op_divisor(op_divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout_err(timeout_err),
    .hi(hi), .lo(lo), .div_start(div_start),
    .div_dividendo(div_dividendo), .div_divisor(div_divisor),
    .div_lo(div_lo), .div_hi(div_hi), .div_fim(div_fim)
  );

  always #5 clock = ~clock;

  // core model: 34-cycle run, fim stays high (stale) until start returns
  int           ccnt;
  bit           dead = 1'b0;
  logic         fim_r = 1'b0;
  logic [W-1:0] qm = '0, rm = '0, ma, mb;
  assign ma      = div_dividendo[W-1] ? (~div_dividendo + 1) : div_dividendo;
  assign mb      = div_divisor[W-1]   ? (~div_divisor + 1)   : div_divisor;
  assign div_fim = fim_r;
  assign div_lo  = qm;
  assign div_hi  = rm;

  always @(posedge clock) begin
    if (reset) begin
      ccnt <= 0; fim_r <= 1'b0;
    end else if (!div_start) begin
      ccnt <= 0;
    end else begin
      ccnt <= ccnt + 1;
      if (dead || ccnt == 1) fim_r <= 1'b0;
      if (!dead && ccnt == 33 && mb != 0) begin
        fim_r <= 1'b1; qm <= ma / mb; rm <= ma % mb;
      end
    end
  end

  typedef struct { logic [W-1:0] lo, hi; logic dz, to; } exp_t;
  exp_t         sb[$];
  int           n_chk = 0, n_pass = 0;
  logic [W-1:0] ref_hi = '0, ref_lo = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit dead_core);
    exp_t   e, o;
    longint sa, sbv, q, r;
    int     n, qn, busy_err, start_err;
    bit     got_done, exp_start;
    e.dz = (b == 0); e.to = (b != 0) && dead_core;
    e.lo = ref_lo; e.hi = ref_hi;
    if (b != 0 && !dead_core) begin
      sa = longint'($signed(a)); sbv = longint'($signed(b));
      q = sa / sbv; r = sa % sbv;
      e.lo = q[W-1:0]; e.hi = r[W-1:0];
      ref_lo = e.lo; ref_hi = e.hi;
    end
    sb.push_back(e);
    dead = dead_core;
    @(negedge clock); op_valid = 1'b1; op_dividend = a; op_divisor = b;
    @(negedge clock); op_valid = 1'b0;
    if (b != 0) chk({tag, "/opnd"}, div_dividendo, a);
    n = 0; qn = -1; busy_err = 0; start_err = 0; got_done = 1'b0;
    while (n < ARM + TMO + 3) begin
      if (n > 0) @(negedge clock);
      if (!busy) busy_err++;
      exp_start = (b != 0) && !done && (qn < 0 || n <= qn);
      if (div_start !== exp_start) start_err++;
      if (qn < 0 && div_start && n >= ARM && div_fim) qn = n;
      if (done) begin got_done = 1'b1; break; end
      n++;
    end
    chk({tag, "/done"}, W'(got_done), W'(1));
    o = sb.pop_front();
    if (got_done) begin
      chk({tag, "/lo"}, lo, o.lo);
      chk({tag, "/hi"}, hi, o.hi);
      chk({tag, "/div_zero"}, W'(div_zero), W'(o.dz));
      chk({tag, "/timeout"}, W'(timeout_err), W'(o.to));
      if (b == 0)          chk({tag, "/lat"}, W'(n), W'(0));
      else if (!dead_core) chk({tag, "/lat"}, W'(n), W'(qn + 2));
      else chk({tag, "/lat_bound"}, W'(n >= TMO && n <= ARM + TMO + 2), W'(1));
    end
    chk({tag, "/busy_err"}, W'(busy_err), W'(0));
    chk({tag, "/start_err"}, W'(start_err), W'(0));
    @(negedge clock);
    chk({tag, "/idle"}, W'({busy, done, div_start}), W'(0));
    chk({tag, "/lo_hold"}, lo, ref_lo);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst/flags", W'({busy, done, div_zero, timeout_err, div_start}), W'(0));
    chk("rst/hi", hi, '0);
    chk("rst/lo", lo, '0);
    chk("rst/opnd", div_dividendo | div_divisor, '0);
    reset = 1'b0;

    run_op("p100_7",   32'd100,        32'd7,          1'b0);
    run_op("n100_7",   32'hFFFFFF9C,   32'd7,          1'b0);
    run_op("p100_n7",  32'd100,        32'hFFFFFFF9,   1'b0);
    run_op("div0",     32'd5,          32'd0,          1'b0);
    run_op("min_m1",   32'h80000000,   32'hFFFFFFFF,   1'b0);
    run_op("timeout",  32'd7,          32'd3,          1'b1);

    // reset 10 cycles into RUN
    @(negedge clock); op_valid = 1'b1; op_dividend = 32'd100; op_divisor = 32'd7;
    @(negedge clock); op_valid = 1'b0;
    repeat (9) @(negedge clock);
    chk("midrst/running", W'({busy, div_start}), W'(3));
    reset = 1'b1;
    @(negedge clock);
    chk("midrst/flags", W'({busy, done, div_start}), W'(0));
    chk("midrst/hi", hi, '0);
    chk("midrst/lo", lo, '0);
    reset = 1'b0; ref_hi = '0; ref_lo = '0;

    run_op("b2b_50_3", 32'd50, 32'd3, 1'b0);
    run_op("b2b_9_4",  32'd9,  32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      if (i[0]) b = {{(W-8){b[W-1]}}, b[7:0]};
      if (b == 0) b = 32'd13;
      run_op("rand", a, b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
